hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It is the producing end of the datapath select lines: it generates the 2-bit forwarding selects consumed by the EX-stage operand muxes. It also generates the stall and flush controls for the PC, IF/ID and ID/EX registers. It tracks the multi-cycle multiply/divide unit with a small FSM so that HI/LO readers wait for the result.

## Interface
- MULDIV_LATENCY, 4: cycles from mul/div issue until HI/LO are valid; legal range 2..15.
- Clk  in  1  rising-edge clock
- ResetN  in  1  asynchronous, active-low reset
- ID_Rs, ID_Rt  in  5  source registers of the instruction in ID
- ID_MulDivStart  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- ID_ReadHiLo  in  1  ID instruction is MFHI/MFLO
- EX_Rs, EX_Rt  in  5  source registers of the instruction in EX
- EX_Rd  in  5  destination of the instruction in EX
- EX_RegWrite, EX_MemRead  in  1  EX control bits
- EX_BranchTaken  in  1  branch/jump resolved taken in EX
- MEM_Rd  in  5; MEM_RegWrite  in  1
- WB_Rd  in  5; WB_RegWrite  in  1
- ForwardA, ForwardB  out  2  operand select: 00 register file, 01 WB result, 10 MEM ALU result
- StallPC, StallIFID  out  1  hold PC / IF-ID register
- FlushIFID, FlushIDEX  out  1  load bubble (zero controls)
- MulDivBusy  out  1  mul/div in flight

## Operation
- Forwarding is combinational from EX/MEM/WB fields.
  - ForwardA = 10 if MEM_RegWrite && MEM_Rd!=0 && MEM_Rd==EX_Rs.
  - Otherwise ForwardA = 01 if WB_RegWrite && WB_Rd!=0 && WB_Rd==EX_Rs.
  - Otherwise ForwardA = 00.
  - ForwardB uses the same rules with EX_Rt.
  - MEM has priority over WB. Register 0 never forwards.
- Load-use condition: EX_MemRead && EX_Rd!=0 && (EX_Rd==ID_Rs || EX_Rd==ID_Rt).
- FSM states: RUN, MULDIV. A 4-bit down-counter Cnt is used in MULDIV.
- RUN:
  - On load-use: StallPC=StallIFID=FlushIDEX=1.
  - Else if ID_MulDivStart: the issue is accepted, and the next state is MULDIV with Cnt=MULDIV_LATENCY-1.
- MULDIV:
  - MulDivBusy=1. Cnt decrements each cycle.
  - When Cnt==0, the next state is RUN.
  - An ID instruction with ID_ReadHiLo or ID_MulDivStart is stalled: StallPC=StallIFID=FlushIDEX=1.
  - Other instructions proceed. Load-use is still detected.
- EX_BranchTaken has top priority in every state:
  - FlushIFID=FlushIDEX=1 and StallPC=StallIFID=0 in that cycle.
  - A concurrent ID_MulDivStart is not accepted, because the flushed instruction is wrong-path.
  - An in-flight mul/div continues counting.
- Simultaneous load-use and ID_MulDivStart in RUN: the stall wins and the issue is not accepted that cycle.

## Timing
- Reset (ResetN low, asynchronous): state=RUN, Cnt=0, MulDivBusy=0. All stall/flush outputs and ForwardA/B read 0 while ResetN is low.
- Reset mid-operation discards any in-flight mul/div tracking.
- Forward, stall and flush outputs are combinational (same cycle as inputs). MulDivBusy is registered, from the state.
- Issue accepted in cycle T: MulDivBusy=1 in cycles T+1 .. T+MULDIV_LATENCY, then 0 at T+MULDIV_LATENCY+1.
- A HI/LO reader in ID is released in cycle T+MULDIV_LATENCY+1.
- A back-to-back mul/div in ID while busy is stalled until RUN. It is then accepted in RUN that same cycle and re-enters MULDIV on the next cycle.
- A load-use stall lasts exactly one cycle. The next cycle has the load in MEM and forwarding 10 takes over.

## Structure
- The shared package holds:
  - Forward select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The FSM state encoding: RUN, MULDIV.
  - The register address width (5).
- The forwarding compare is natural as one sub-module, forward_sel, instantiated twice (Rs, Rt).
- The FSM, counter and stall/flush logic live in hazard_unit.

## Test plan
- MEM_RegWrite=1, MEM_Rd=8, WB_RegWrite=1, WB_Rd=8, EX_Rs=8 -> ForwardA=10. Then MEM_RegWrite=0 -> ForwardA=01. With EX_Rs=0 and all Rd=0 -> 00.
- EX_MemRead=1, EX_Rd=9, ID_Rt=9 -> StallPC=StallIFID=FlushIDEX=1 for one cycle. The next cycle has MEM_Rd=9, EX_Rt=9 -> ForwardB=10, with no stall.
- MULDIV_LATENCY=4, ID_MulDivStart at T, then ID_ReadHiLo held from T+1 -> MulDivBusy=1 and stall asserted T+1..T+4; both 0 at T+5.
- In MULDIV, EX_BranchTaken=1 with ID_ReadHiLo=1 -> FlushIFID=FlushIDEX=1 and StallPC=0. MulDivBusy still drops on schedule.
- ResetN pulled low at T+2 of a mul/div -> MulDivBusy=0 immediately. After release, ID_ReadHiLo causes no stall.
- Load-use and ID_MulDivStart in the same cycle -> stall only, MulDivBusy stays 0. The issue is accepted the following cycle.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_unit_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Operand forward select for one EX source register; MEM beats WB, r0 never forwards.
module forward_sel
    import hazard_unit_pkg::*;
(
    input  reg_addr_t  src_i,
    input  reg_addr_t  mem_rd_i,
    input  logic       mem_we_i,
    input  reg_addr_t  wb_rd_i,
    input  logic       wb_we_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (mem_we_i && (mem_rd_i != '0) && (mem_rd_i == src_i)) begin
            fwd_o = FWD_MEM;
        end else if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects, load-use / mul-div stalls and branch flushes for the
// five-stage core; a two-state FSM tracks the multi-cycle mul/div unit.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = 4
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  reg_addr_t  ID_Rs,
    input  reg_addr_t  ID_Rt,
    input  logic       ID_MulDivStart,
    input  logic       ID_ReadHiLo,
    input  reg_addr_t  EX_Rs,
    input  reg_addr_t  EX_Rt,
    input  reg_addr_t  EX_Rd,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic       EX_BranchTaken,
    input  reg_addr_t  MEM_Rd,
    input  logic       MEM_RegWrite,
    input  reg_addr_t  WB_Rd,
    input  logic       WB_RegWrite,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       StallPC,
    output logic       StallIFID,
    output logic       FlushIFID,
    output logic       FlushIDEX,
    output logic       MulDivBusy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             stall, flush_ifid, flush_idex;
    logic [1:0]       fwd_a, fwd_b;

    forward_sel u_fwd_a (
        .src_i    (EX_Rs),
        .mem_rd_i (MEM_Rd),
        .mem_we_i (MEM_RegWrite),
        .wb_rd_i  (WB_Rd),
        .wb_we_i  (WB_RegWrite),
        .fwd_o    (fwd_a)
    );

    forward_sel u_fwd_b (
        .src_i    (EX_Rt),
        .mem_rd_i (MEM_Rd),
        .mem_we_i (MEM_RegWrite),
        .wb_rd_i  (WB_Rd),
        .wb_we_i  (WB_RegWrite),
        .fwd_o    (fwd_b)
    );

    assign load_use = EX_MemRead && (EX_Rd != '0) &&
                      ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt));

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        case (state_q)
            RUN: begin
                // A taken branch squashes the ID instruction, so no issue from it.
                if (EX_BranchTaken) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    stall      = 1'b1;
                    flush_idex = 1'b1;
                end else if (ID_MulDivStart) begin
                    state_d = MULDIV;
                    cnt_d   = CNT_W'(MULDIV_LATENCY - 1);
                end
            end
            MULDIV: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (EX_BranchTaken) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (ID_ReadHiLo || ID_MulDivStart || load_use) begin
                    stall      = 1'b1;
                    flush_idex = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Combinational outputs are forced quiet while reset is held.
    assign ForwardA   = ResetN ? fwd_a : FWD_RF;
    assign ForwardB   = ResetN ? fwd_b : FWD_RF;
    assign StallPC    = ResetN & stall;
    assign StallIFID  = ResetN & stall;
    assign FlushIFID  = ResetN & flush_ifid;
    assign FlushIDEX  = ResetN & flush_idex;
    assign MulDivBusy = (state_q == MULDIV);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with MULDIV_LATENCY=4.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic       Clk = 1'b0;
    logic       ResetN;
    reg_addr_t  ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_Rd, MEM_Rd, WB_Rd;
    logic       ID_MulDivStart, ID_ReadHiLo, EX_RegWrite, EX_MemRead, EX_BranchTaken;
    logic       MEM_RegWrite, WB_RegWrite;
    logic [1:0] ForwardA, ForwardB;
    logic       StallPC, StallIFID, FlushIFID, FlushIDEX, MulDivBusy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    hazard_unit #(.MULDIV_LATENCY(4)) dut (
        .Clk            (Clk),
        .ResetN         (ResetN),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_MulDivStart (ID_MulDivStart),
        .ID_ReadHiLo    (ID_ReadHiLo),
        .EX_Rs          (EX_Rs),
        .EX_Rt          (EX_Rt),
        .EX_Rd          (EX_Rd),
        .EX_RegWrite    (EX_RegWrite),
        .EX_MemRead     (EX_MemRead),
        .EX_BranchTaken (EX_BranchTaken),
        .MEM_Rd         (MEM_Rd),
        .MEM_RegWrite   (MEM_RegWrite),
        .WB_Rd          (WB_Rd),
        .WB_RegWrite    (WB_RegWrite),
        .ForwardA       (ForwardA),
        .ForwardB       (ForwardB),
        .StallPC        (StallPC),
        .StallIFID      (StallIFID),
        .FlushIFID      (FlushIFID),
        .FlushIDEX      (FlushIDEX),
        .MulDivBusy     (MulDivBusy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {StallPC, StallIFID, FlushIFID, FlushIDEX}
    function automatic logic [3:0] ctl();
        return {StallPC, StallIFID, FlushIFID, FlushIDEX};
    endfunction

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        {ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_Rd, MEM_Rd, WB_Rd} = '0;
        {ID_MulDivStart, ID_ReadHiLo, EX_RegWrite, EX_MemRead, EX_BranchTaken} = '0;
        {MEM_RegWrite, WB_RegWrite} = '0;
    endtask

    initial begin
        clear_inputs();
        ResetN = 1'b0;
        // Reset: outputs quiet even with matching forward and load-use inputs
        MEM_RegWrite = 1'b1; MEM_Rd = 5'd8; EX_Rs = 5'd8;
        EX_MemRead = 1'b1; EX_Rd = 5'd9; ID_Rt = 5'd9;
        #2;
        chk("rst_fwdA", {2'b0, ForwardA}, 4'h0);
        chk("rst_ctl", ctl(), 4'h0);
        chk("rst_busy", {3'b0, MulDivBusy}, 4'h0);
        next_cycle();
        clear_inputs();
        ResetN = 1'b1;
        next_cycle();

        // Forwarding priority
        MEM_RegWrite = 1'b1; MEM_Rd = 5'd8; WB_RegWrite = 1'b1; WB_Rd = 5'd8; EX_Rs = 5'd8;
        @(negedge Clk); chk("fwdA_mem", {2'b0, ForwardA}, 4'h2);
        chk("fwdB_rf", {2'b0, ForwardB}, 4'h0);
        next_cycle(); MEM_RegWrite = 1'b0;
        @(negedge Clk); chk("fwdA_wb", {2'b0, ForwardA}, 4'h1);
        next_cycle(); MEM_RegWrite = 1'b1; MEM_Rd = 5'd0; WB_Rd = 5'd0; EX_Rs = 5'd0;
        @(negedge Clk); chk("fwdA_r0", {2'b0, ForwardA}, 4'h0);
        next_cycle(); MEM_Rd = 5'd3; WB_Rd = 5'd3; EX_Rt = 5'd3;
        @(negedge Clk); chk("fwdB_mem", {2'b0, ForwardB}, 4'h2);
        next_cycle(); MEM_Rd = 5'd4; WB_Rd = 5'd3;
        @(negedge Clk); chk("fwdB_wb", {2'b0, ForwardB}, 4'h1);

        // Load-use stall then MEM forward
        next_cycle(); clear_inputs();
        EX_MemRead = 1'b1; EX_Rd = 5'd9; ID_Rt = 5'd9;
        @(negedge Clk); chk("lu_ctl", ctl(), 4'hD);
        next_cycle(); EX_MemRead = 1'b0; EX_Rd = 5'd0; MEM_Rd = 5'd9; MEM_RegWrite = 1'b1; EX_Rt = 5'd9;
        @(negedge Clk); chk("lu_fwdB", {2'b0, ForwardB}, 4'h2);
        chk("lu_nostall", ctl(), 4'h0);

        // Mul/div issue then HI/LO reader
        next_cycle(); clear_inputs(); ID_MulDivStart = 1'b1;
        @(negedge Clk); chk("md_issue_ctl", ctl(), 4'h0);
        chk("md_issue_busy", {3'b0, MulDivBusy}, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); ID_MulDivStart = 1'b0; ID_ReadHiLo = 1'b1;
            @(negedge Clk); chk($sformatf("md_busy_T%0d", i), {3'b0, MulDivBusy}, 4'h1);
            chk($sformatf("md_stall_T%0d", i), ctl(), 4'hD);
        end
        next_cycle();
        @(negedge Clk); chk("md_busy_T5", {3'b0, MulDivBusy}, 4'h0);
        chk("md_release_T5", ctl(), 4'h0);

        // Branch during MULDIV, then branch blocks a new issue in RUN
        next_cycle(); clear_inputs(); ID_MulDivStart = 1'b1;
        next_cycle(); ID_MulDivStart = 1'b0; ID_ReadHiLo = 1'b1;
        @(negedge Clk); chk("br_pre_stall", ctl(), 4'hD);
        next_cycle(); EX_BranchTaken = 1'b1;
        @(negedge Clk); chk("br_ctl", ctl(), 4'h3);
        chk("br_busy", {3'b0, MulDivBusy}, 4'h1);
        next_cycle(); EX_BranchTaken = 1'b0;
        next_cycle();
        @(negedge Clk); chk("br_busy_T4", {3'b0, MulDivBusy}, 4'h1);
        next_cycle(); ID_ReadHiLo = 1'b0; EX_BranchTaken = 1'b1; ID_MulDivStart = 1'b1;
        @(negedge Clk); chk("br_busy_T5", {3'b0, MulDivBusy}, 4'h0);
        chk("br_run_ctl", ctl(), 4'h3);
        next_cycle(); EX_BranchTaken = 1'b0; ID_MulDivStart = 1'b0;
        @(negedge Clk); chk("br_no_issue", {3'b0, MulDivBusy}, 4'h0);

        // Reset mid mul/div
        next_cycle(); ID_MulDivStart = 1'b1;
        next_cycle(); ID_MulDivStart = 1'b0; ID_ReadHiLo = 1'b1;
        @(negedge Clk); chk("rm_busy_T1", {3'b0, MulDivBusy}, 4'h1);
        next_cycle(); ResetN = 1'b0;
        #1; chk("rm_busy_now", {3'b0, MulDivBusy}, 4'h0);
        chk("rm_ctl_rst", ctl(), 4'h0);
        @(negedge Clk); ResetN = 1'b1;
        next_cycle();
        @(negedge Clk); chk("rm_no_stall", ctl(), 4'h0);
        chk("rm_busy_after", {3'b0, MulDivBusy}, 4'h0);

        // Load-use and issue in the same cycle
        next_cycle(); clear_inputs();
        EX_MemRead = 1'b1; EX_Rd = 5'd7; ID_Rs = 5'd7; ID_MulDivStart = 1'b1;
        @(negedge Clk); chk("lumd_ctl", ctl(), 4'hD);
        next_cycle(); EX_MemRead = 1'b0; EX_Rd = 5'd0;
        @(negedge Clk); chk("lumd_busy0", {3'b0, MulDivBusy}, 4'h0);
        chk("lumd_accept_ctl", ctl(), 4'h0);
        next_cycle(); ID_MulDivStart = 1'b0;
        @(negedge Clk); chk("lumd_busy1", {3'b0, MulDivBusy}, 4'h1);

        // Back-to-back mul/div held until RUN
        next_cycle(); next_cycle(); next_cycle();
        next_cycle(); ID_MulDivStart = 1'b1;
        @(negedge Clk); chk("b2b_first", {3'b0, MulDivBusy}, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            @(negedge Clk); chk($sformatf("b2b_stall_T%0d", i), ctl(), 4'hD);
        end
        next_cycle();
        @(negedge Clk); chk("b2b_accept", ctl(), 4'h0);
        chk("b2b_run", {3'b0, MulDivBusy}, 4'h0);
        next_cycle(); ID_MulDivStart = 1'b0;
        @(negedge Clk); chk("b2b_busy", {3'b0, MulDivBusy}, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
